// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed hex-to-7-segment scheduler: one shared decoder walks a digit
// register file and latches each digit's (optionally blanked/blinking) pattern.
module hex_scan_ctrl #(
  parameter int NUM_DIGITS   = 6,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 50
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [2:0]              wr_addr,
  input  logic [3:0]              wr_data,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7*NUM_DIGITS-1:0] seg_out,
  output logic [2:0]              scan_idx,
  output logic                    frame_tick,
  output logic                    wr_err
);

  localparam int         DIV_W    = $clog2(REFRESH_DIV);
  localparam int         FRM_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [3:0] ND       = 4'(NUM_DIGITS);
  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, LATCH} state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              scan_q, scan_d;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
  logic [3:0]              digit_q [NUM_DIGITS];
  logic [3:0]              digit_d [NUM_DIGITS];
  logic [3:0]              cap_q, cap_d;
  logic                    dark_q, dark_d;
  logic                    blink_q, blink_d;
  logic [FRM_W-1:0]        frm_q, frm_d;
  logic                    ftick_q, ftick_d;
  logic                    err_q, err_d;
  logic                    tick;
  logic                    wr_fire;

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    case (n)
      4'h0: hex_decode = 7'h40;  4'h1: hex_decode = 7'h79;
      4'h2: hex_decode = 7'h24;  4'h3: hex_decode = 7'h30;
      4'h4: hex_decode = 7'h19;  4'h5: hex_decode = 7'h12;
      4'h6: hex_decode = 7'h02;  4'h7: hex_decode = 7'h78;
      4'h8: hex_decode = 7'h00;  4'h9: hex_decode = 7'h10;
      4'hA: hex_decode = 7'h08;  4'hB: hex_decode = 7'h03;
      4'hC: hex_decode = 7'h46;  4'hD: hex_decode = 7'h21;
      4'hE: hex_decode = 7'h06;  default: hex_decode = 7'h0E;
    endcase
  endfunction

  assign tick     = (cnt_q == DIV_W'(REFRESH_DIV - 1));
  assign wr_ready = (state_q != FETCH);
  assign wr_fire  = wr_valid && wr_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    scan_d  = scan_q;
    seg_d   = seg_q;
    digit_d = digit_q;
    cap_d   = cap_q;
    dark_d  = dark_q;
    blink_d = blink_q;
    frm_d   = frm_q;
    ftick_d = 1'b0;
    err_d   = err_q;

    // Out-of-range writes still complete the handshake but only flag the error.
    if (wr_fire) begin
      if ({1'b0, wr_addr} < ND) digit_d[wr_addr] = wr_data;
      else                      err_d = 1'b1;
    end

    case (state_q)
      IDLE: if (tick) state_d = FETCH;
      FETCH: begin
        cap_d   = digit_q[scan_q];
        dark_d  = blank_mask[scan_q] | (blink_mask[scan_q] & blink_q);
        state_d = LATCH;
      end
      LATCH: begin
        seg_d[int'(scan_q)*7 +: 7] = dark_q ? 7'h7F : hex_decode(cap_q);
        if (scan_q == LAST_IDX) begin
          scan_d  = '0;
          ftick_d = 1'b1;
          if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
            frm_d   = '0;
            blink_d = ~blink_q;
          end else begin
            frm_d = frm_q + 1'b1;
          end
        end else begin
          scan_d = scan_q + 3'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      scan_q  <= '0;
      seg_q   <= '1;
      cap_q   <= '0;
      dark_q  <= 1'b0;
      blink_q <= 1'b0;
      frm_q   <= '0;
      ftick_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scan_q  <= scan_d;
      seg_q   <= seg_d;
      cap_q   <= cap_d;
      dark_q  <= dark_d;
      blink_q <= blink_d;
      frm_q   <= frm_d;
      ftick_q <= ftick_d;
      err_q   <= err_d;
      digit_q <= digit_d;
    end
  end

  assign seg_out    = seg_q;
  assign scan_idx   = scan_q;
  assign frame_tick = ftick_q;
  assign wr_err     = err_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Scoreboard bench for hex_scan_ctrl: stimulus queues expected frame images,
// a monitor compares seg_out on every frame_tick and tracks scan stepping.
module tb_hex_scan_ctrl;
  localparam int ND = 6;
  localparam int RD = 4;
  localparam int BF = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [2:0]      wr_addr = 3'd0;
  logic [3:0]      wr_data = 4'd0;
  logic [ND-1:0]   blank_mask = '0;
  logic [ND-1:0]   blink_mask = '0;
  logic [7*ND-1:0] seg_out;
  logic [2:0]      scan_idx;
  logic            frame_tick;
  logic            wr_err;

  int checks = 0;
  int errors = 0;
  logic [7*ND-1:0] exp_q [$];

  hex_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .blank_mask(blank_mask),
    .blink_mask(blink_mask), .seg_out(seg_out), .scan_idx(scan_idx),
    .frame_tick(frame_tick), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7*ND-1:0] frame(input logic [6:0] s5, s4, s3, s2, s1, s0);
    return {s5, s4, s3, s2, s1, s0};
  endfunction

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 80);
    if (!frame_tick) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout actual=no_tick required=tick_within_80");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_seg"},   64'(seg_out),    64'({7*ND{1'b1}}));
    chk({tag, "_scan"},  64'(scan_idx),   64'd0);
    chk({tag, "_ftick"}, 64'(frame_tick), 64'd0);
    chk({tag, "_err"},   64'(wr_err),     64'd0);
    chk({tag, "_ready"}, 64'(wr_ready),   64'd1);
  endtask

  // Monitor: frame images, frame period and scan stepping.
  initial begin
    int since = 0;
    logic seen = 1'b0;
    logic [2:0] prev_scan = 3'd0;
    logic [7*ND-1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        since = 0;
        seen = 1'b0;
        prev_scan = 3'd0;
      end else begin
        since++;
        if (scan_idx != prev_scan) begin
          chk("scan_step", 64'(scan_idx),
              64'((prev_scan == 3'(ND - 1)) ? 3'd0 : prev_scan + 3'd1));
          prev_scan = scan_idx;
        end
        if (frame_tick) begin
          if (seen) chk("frame_period", 64'(since), 64'(ND * RD));
          seen = 1'b1;
          since = 0;
          chk("scan_at_tick", 64'(scan_idx), 64'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame actual=%0h required=none", seg_out);
          end else begin
            e = exp_q.pop_front();
            chk("frame_seg", 64'(seg_out), 64'(e));
          end
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    exp_q.push_back(frame(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40));
    rst = 1'b0;

    wait_frame();  // frame 1 done; IDLE write to digit 2, then a write held across FETCH
    chk("ready_idle", 64'(wr_ready), 64'd1);
    wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 4'hA;
    exp_q.push_back(frame(7'h40, 7'h40, 7'h40, 7'h08, 7'h30, 7'h40));
    @(negedge clk); wr_valid = 1'b0;
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 4'h3;
    chk("ready_fetch", 64'(wr_ready), 64'd0);
    @(negedge clk);
    chk("ready_latch", 64'(wr_ready), 64'd1);
    @(negedge clk); wr_valid = 1'b0;

    wait_frame();  // frame 2 done; blank digit 0 and blink digit 5
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 4'h5;
    blank_mask = 6'b000001;
    blink_mask = 6'b100000;
    exp_q.push_back(frame(7'h7F, 7'h40, 7'h40, 7'h08, 7'h30, 7'h7F));
    @(negedge clk); wr_addr = 3'd5; wr_data = 4'hF;
    @(negedge clk); wr_valid = 1'b0;

    wait_frame();  // frame 3 done; unblank digit 0
    chk("err_clear", 64'(wr_err), 64'd0);
    blank_mask = '0;
    exp_q.push_back(frame(7'h7F, 7'h40, 7'h40, 7'h08, 7'h30, 7'h12));

    wait_frame();  // frame 4 done; out-of-range write
    wr_valid = 1'b1; wr_addr = 3'd7; wr_data = 4'h9;
    chk("ready_bad_addr", 64'(wr_ready), 64'd1);
    exp_q.push_back(frame(7'h0E, 7'h40, 7'h40, 7'h08, 7'h30, 7'h12));
    exp_q.push_back(frame(7'h0E, 7'h40, 7'h40, 7'h08, 7'h30, 7'h12));
    exp_q.push_back(frame(7'h7F, 7'h40, 7'h40, 7'h08, 7'h30, 7'h12));
    @(negedge clk); wr_valid = 1'b0;
    chk("err_set", 64'(wr_err), 64'd1);

    wait_frame();
    wait_frame();
    wait_frame();  // frame 7 done; reset during digit 1's FETCH
    repeat (6) @(negedge clk);
    chk("mid_fetch_ready", 64'(wr_ready), 64'd0);
    chk("mid_fetch_scan", 64'(scan_idx), 64'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    exp_q.push_back(frame(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40));
    rst = 1'b0;
    wait_frame();
    repeat (2) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
